tug_field: RTL and testbench

Playfield and scoring stage of the Tug-of-War game, sitting directly downstream of the master controller FSM. It consumes the controller's `clr`, `leds_on` and `led_ctrl` outputs together with the two players' press pulses. It tracks the rope position, detects round wins and false starts, keeps per-player scores and drives the LED bar. Its `winrnd` output closes the loop back to the controller.

---
 rtl/tug_field.sv | 148 ++++++++++++++
 tb/tb_tug_field.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tug_field.sv
// Tug-of-War playfield: rope position, round win / false-start detection, scores and LED bar.
// Press at cycle N updates pos/winrnd/winner/scores at edge N+1; leds follow pos one edge later.
module tug_field #(
  parameter int NUM_LEDS = 7,
  parameter int SCORE_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pl,
  input  logic                pr,
  input  logic                clr,
  input  logic                leds_on,
  input  logic [1:0]          led_ctrl,
  output logic                winrnd,
  output logic                winner,
  output logic [NUM_LEDS-1:0] leds,
  output logic [SCORE_W-1:0]  score_l,
  output logic [SCORE_W-1:0]  score_r
);

  localparam int PW = $clog2(NUM_LEDS);
  localparam logic [PW-1:0] CENTER = PW'((NUM_LEDS - 1) / 2);
  localparam logic [PW-1:0] LAST   = PW'(NUM_LEDS - 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [SCORE_W-1:0] S_MAX = '1;
  localparam logic [SCORE_W-1:0] S_ONE = SCORE_W'(1);

  typedef enum logic {FROZEN, LIVE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PW-1:0]       pos;
  logic [PW-1:0]       pos_nxt;
  logic                clr_q;
  logic                win;
  logic                win_left;
  logic                only_l;
  logic                only_r;
  logic                dark;
  logic                play;
  logic [NUM_LEDS-1:0] leds_nxt;

  // Simultaneous presses cancel in every mode, so only lone presses matter.
  assign only_l = pl & ~pr;
  assign only_r = pr & ~pl;
  assign dark   = (led_ctrl == 2'b00);
  assign play   = (led_ctrl == 2'b10) || (led_ctrl == 2'b01);

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    win       = 1'b0;
    win_left  = 1'b0;
    case (state)
      FROZEN: begin
        // Falling edge of clr re-arms; this recenter cycle ignores presses.
        if (!clr && clr_q) begin
          state_nxt = LIVE;
          pos_nxt   = CENTER;
        end
      end
      LIVE: begin
        if (clr) begin
          state_nxt = FROZEN;
        end else if (dark) begin
          if (only_l) begin
            win      = 1'b1;
            win_left = 1'b0;
            pos_nxt  = '0;
          end else if (only_r) begin
            win      = 1'b1;
            win_left = 1'b1;
            pos_nxt  = LAST;
          end
        end else if (play) begin
          if (only_l) begin
            if (pos < LAST) begin
              pos_nxt = pos + P_ONE;
            end else begin
              win      = 1'b1;
              win_left = 1'b1;
            end
          end else if (only_r) begin
            if (pos != '0) begin
              pos_nxt = pos - P_ONE;
            end else begin
              win      = 1'b1;
              win_left = 1'b0;
            end
          end
        end
        if (win) begin
          state_nxt = FROZEN;
        end
      end
      default: state_nxt = FROZEN;
    endcase
  end

  // LED bar is driven from the registered pos, hence one extra edge after a move.
  always_comb begin
    leds_nxt = '0;
    if (!leds_on) begin
      leds_nxt = '0;
    end else if (led_ctrl == 2'b11) begin
      leds_nxt = '1;
    end else if (led_ctrl == 2'b00) begin
      leds_nxt = '0;
    end else begin
      leds_nxt[pos] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FROZEN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos     <= CENTER;
      clr_q   <= 1'b1;
      winrnd  <= 1'b0;
      winner  <= 1'b0;
      score_l <= '0;
      score_r <= '0;
      leds    <= '0;
    end else begin
      pos    <= pos_nxt;
      clr_q  <= clr;
      winrnd <= win;
      leds   <= leds_nxt;
      if (win) begin
        winner <= win_left;
        if (win_left && score_l != S_MAX) begin
          score_l <= score_l + S_ONE;
        end
        if (!win_left && score_r != S_MAX) begin
          score_r <= score_r + S_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_tug_field.sv
// Directed bench for tug_field: rule-level reference model compared every cycle, plus literal checks.
module tb_tug_field;
  localparam int N  = 7;
  localparam int SW = 4;
  localparam int C  = (N - 1) / 2;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          pl, pr, clr, leds_on;
  logic [1:0]    led_ctrl;
  logic          winrnd, winner;
  logic [N-1:0]  leds;
  logic [SW-1:0] score_l, score_r;

  int checks = 0;
  int failures = 0;
  int wins_seen = 0;
  int w0;

  // Reference model state
  int           m_pos, m_sl, m_sr;
  bit           m_live, m_clrq, m_winner, m_winrnd;
  logic [N-1:0] m_leds;

  tug_field #(.NUM_LEDS(N), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .pl(pl), .pr(pr), .clr(clr), .leds_on(leds_on),
    .led_ctrl(led_ctrl), .winrnd(winrnd), .winner(winner), .leds(leds),
    .score_l(score_l), .score_r(score_r)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = C; m_clrq = 1'b1; m_live = 1'b0; m_winrnd = 1'b0;
    m_winner = 1'b0; m_sl = 0; m_sr = 0; m_leds = '0;
  endtask

  task automatic award(input bit left);
    m_winrnd = 1'b1;
    m_winner = left;
    m_live   = 1'b0;
    if (left) m_sl = (m_sl < SMAX) ? m_sl + 1 : SMAX;
    else      m_sr = (m_sr < SMAX) ? m_sr + 1 : SMAX;
  endtask

  task automatic model_step();
    logic [N-1:0] one;
    int np;
    one = 1;
    // Display uses the position as it stood before this edge.
    if (!leds_on || led_ctrl == 2'b00) m_leds = '0;
    else if (led_ctrl == 2'b11)        m_leds = '1;
    else                               m_leds = one << m_pos;
    m_winrnd = 1'b0;
    if (!m_live) begin
      if (!clr && m_clrq) begin
        m_live = 1'b1;
        m_pos  = C;
      end
    end else if (clr) begin
      m_live = 1'b0;
    end else if (pl != pr) begin
      if (led_ctrl == 2'b00) begin
        award(pr);
        m_pos = pr ? N - 1 : 0;
      end else if (led_ctrl != 2'b11) begin
        np = m_pos + (pl ? 1 : -1);
        if (np < 0)          award(1'b0);
        else if (np > N - 1) award(1'b1);
        else                 m_pos = np;
      end
    end
    m_clrq = clr;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("leds", leds, m_leds);
      chk("winrnd", winrnd, m_winrnd);
      chk("winner", winner, m_winner);
      chk("score_l", score_l, m_sl);
      chk("score_r", score_r, m_sr);
      if (winrnd) wins_seen++;
    end
  end

  task automatic pulse_l();
    pl = 1'b1; @(negedge clk); pl = 1'b0;
  endtask

  task automatic pulse_r();
    pr = 1'b1; @(negedge clk); pr = 1'b0;
  endtask

  initial begin
    model_reset();
    rst = 1'b1; pl = 1'b0; pr = 1'b0; clr = 1'b1; leds_on = 1'b1; led_ctrl = 2'b11;
    #12;
    chk("rst_leds", leds, 0);
    chk("rst_winrnd", winrnd, 0);
    chk("rst_winner", winner, 0);
    chk("rst_scores", {score_l, score_r}, 0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("frozen_all_on", leds, 7'h7F);

    // Arm in dark, then show position at center
    clr = 1'b0; led_ctrl = 2'b00;
    @(negedge clk);
    chk("armed_dark", leds, 7'h00);
    led_ctrl = 2'b10;
    @(negedge clk);
    chk("center", leds, 7'h08);

    // Left walks to the end and wins exactly once
    w0 = wins_seen;
    for (int i = 0; i < 5; i++) begin
      pulse_l();
      @(negedge clk); @(negedge clk);
      chk("walk_left", leds, 7'h08 << ((i + 1 < 3) ? i + 1 : 3));
    end
    chk("left_win_count", wins_seen - w0, 1);
    chk("left_winner", winner, 1);
    chk("left_score", score_l, 1);

    // False start by right in dark gives left the round
    clr = 1'b1; @(negedge clk);
    clr = 1'b0; led_ctrl = 2'b00; @(negedge clk);
    pulse_r();
    chk("fs_winrnd", winrnd, 1);
    chk("fs_winner", winner, 1);
    chk("fs_score_l", score_l, 2);
    clr = 1'b1; led_ctrl = 2'b10;
    @(negedge clk);
    chk("fs_pos_shown", leds, 7'h40);

    // Simultaneous presses in dark and in play
    w0 = wins_seen;
    clr = 1'b0; led_ctrl = 2'b00; @(negedge clk);
    pl = 1'b1; pr = 1'b1; @(negedge clk); pl = 1'b0; pr = 1'b0;
    led_ctrl = 2'b10; @(negedge clk);
    pl = 1'b1; pr = 1'b1; @(negedge clk); pl = 1'b0; pr = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("both_no_move", leds, 7'h08);
    chk("both_no_win", wins_seen - w0, 0);
    chk("both_scores", {score_l, score_r}, {4'd2, 4'd0});

    // Right walks down and wins in play; later presses are ignored
    for (int i = 0; i < 4; i++) begin
      pulse_r(); @(negedge clk);
    end
    @(negedge clk);
    chk("right_winner", winner, 0);
    chk("right_score", score_r, 1);
    chk("right_pos", leds, 7'h01);
    w0 = wins_seen;
    pulse_r(); pulse_l(); pulse_r();
    @(negedge clk);
    chk("frozen_no_win", wins_seen - w0, 0);

    // Re-arm: press on recenter cycle ignored, next one moves
    clr = 1'b1; @(negedge clk);
    clr = 1'b0; pulse_l();
    pulse_l();
    @(negedge clk);
    chk("rearm_move", leds, 7'h10);

    // Score saturation through repeated false starts
    for (int i = 0; i < 16; i++) begin
      clr = 1'b1; @(negedge clk);
      clr = 1'b0; led_ctrl = 2'b00; @(negedge clk);
      pulse_r(); @(negedge clk);
    end
    chk("sat_score_l", score_l, 4'hF);
    chk("sat_score_r", score_r, 1);

    // Asynchronous reset while winrnd is high
    clr = 1'b1; @(negedge clk);
    clr = 1'b0; @(negedge clk);
    pr = 1'b1; @(negedge clk); pr = 1'b0;
    chk("pre_rst_winrnd", winrnd, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_winrnd", winrnd, 0);
    chk("arst_winner", winner, 0);
    chk("arst_leds", leds, 0);
    chk("arst_scores", {score_l, score_r}, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
